// File: rtl/alu_acc.sv
// ---------------------------------------------------------------------------
// alu_acc
//   Arithmetic/logic unit of the 8-bit nanoprocessor. It holds the
//   accumulator, the carry and zero flag registers and the output port
//   register. The ALU is combinational from I, ACC, D and C. Results are
//   committed on the controller's EXE strobes.
//
//   Strobe semantics: there is no valid/ready handshake. load_ACC and
//   load_OUT are single-cycle pulses from the controller and are never
//   back-pressured. Every edge that sees a strobe acts on it.
//   Back-to-back pulses chain through the freshly written ACC.
//
// Ports
//   clk      : clock; all state updates on its rising edge
//   reset    : synchronous active-high reset; overrides both strobes
//   I        : opcode from the instruction register (stable in EXE)
//   D        : operand word from data memory (valid in EXE)
//   load_ACC : commit ALU result, C and Z this edge (opcodes 1..12 only)
//   load_OUT : copy ACC into OUT this edge when I is OUT (13)
//   ACC      : accumulator register; also the memory write data
//   Z        : zero flag register
//   C        : carry flag register
//   OUT      : output port register
// ---------------------------------------------------------------------------
module alu_acc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       I,
   input  logic [WIDTH-1:0] D,
   input  logic             load_ACC,
   input  logic             load_OUT,
   output logic [WIDTH-1:0] ACC,
   output logic             Z,
   output logic             C,
   output logic [WIDTH-1:0] OUT
);

   localparam logic [7:0] OP_XOR = 8'd1;
   localparam logic [7:0] OP_AND = 8'd2;
   localparam logic [7:0] OP_OR  = 8'd3;
   localparam logic [7:0] OP_ADD = 8'd4;
   localparam logic [7:0] OP_ADC = 8'd5;
   localparam logic [7:0] OP_SUB = 8'd6;
   localparam logic [7:0] OP_SBC = 8'd7;
   localparam logic [7:0] OP_ROL = 8'd8;
   localparam logic [7:0] OP_ROR = 8'd9;
   localparam logic [7:0] OP_LDA = 8'd10;
   localparam logic [7:0] OP_LSL = 8'd11;
   localparam logic [7:0] OP_LSR = 8'd12;
   localparam logic [7:0] OP_OUT = 8'd13;

   // Zero-extended operands so every sum is formed at WIDTH+1 bits. The top
   // bit of the sum is the carry out.
   logic [WIDTH:0] acc_x;
   logic [WIDTH:0] d_x;
   logic [WIDTH:0] nd_x;
   logic [WIDTH:0] c_x;
   logic [WIDTH:0] sum;

   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             op_valid;   // opcode is one of the twelve ALU operations

   assign acc_x = {1'b0, ACC};
   assign d_x   = {1'b0, D};
   assign nd_x  = {1'b0, ~D};
   assign c_x   = {{WIDTH{1'b0}}, C};

   always_comb begin
      sum      = '0;
      alu_res  = ACC;
      alu_c    = C;
      op_valid = 1'b1;
      unique case (I)
         OP_XOR: alu_res = ACC ^ D;
         OP_AND: alu_res = ACC & D;
         OP_OR:  alu_res = ACC | D;
         OP_ADD: begin
            sum     = acc_x + d_x;
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         OP_ADC: begin
            sum     = acc_x + d_x + c_x;
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         // Subtraction is addition of the one's complement; carry out of 1
         // means no borrow occurred.
         OP_SUB: begin
            sum     = acc_x + nd_x + {{WIDTH{1'b0}}, 1'b1};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         OP_SBC: begin
            sum     = acc_x + nd_x + c_x;
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         // Rotates go through the carry: a WIDTH+1 bit ring.
         OP_ROL: begin
            alu_res = {ACC[WIDTH-2:0], C};
            alu_c   = ACC[WIDTH-1];
         end
         OP_ROR: begin
            alu_res = {C, ACC[WIDTH-1:1]};
            alu_c   = ACC[0];
         end
         OP_LDA: alu_res = D;
         OP_LSL: begin
            alu_res = {ACC[WIDTH-2:0], 1'b0};
            alu_c   = ACC[WIDTH-1];
         end
         OP_LSR: begin
            alu_res = {1'b0, ACC[WIDTH-1:1]};
            alu_c   = ACC[0];
         end
         default: op_valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ACC <= '0;
         C   <= 1'b0;
         Z   <= 1'b0;
         OUT <= '0;
      end else begin
         // Undefined opcodes leave ACC, C and Z untouched, including opcode 13.
         if (load_ACC && op_valid) begin
            ACC <= alu_res;
            C   <= alu_c;
            Z   <= (alu_res == '0);
         end
         // load_OUT fires every EXE cycle, so it must be qualified by the
         // opcode. OUT samples the pre-edge ACC.
         if (load_OUT && (I == OP_OUT)) begin
            OUT <= ACC;
         end
      end
   end

endmodule

// File: tb/tb_alu_acc.sv
// ---------------------------------------------------------------------------
// tb_alu_acc
//   Directed-vector bench for alu_acc. A behavioural model using integer
//   arithmetic predicts {OUT,Z,C,ACC} after every edge. The prediction is
//   pushed into exp_q, and a compare process checks it on the falling edge.
//   Hand-computed literals pin the model at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_alu_acc;

   localparam int WIDTH = 8;

   logic             clk;
   logic             reset;
   logic [7:0]       I;
   logic [WIDTH-1:0] D;
   logic             load_ACC;
   logic             load_OUT;
   logic [WIDTH-1:0] ACC;
   logic             Z;
   logic             C;
   logic [WIDTH-1:0] OUT;

   int total = 0;
   int bad   = 0;

   // {OUT, Z, C, ACC}
   logic [2*WIDTH+1:0] exp_q[$];

   // Model state, plain integers
   int m_acc = 0;
   int m_c   = 0;
   int m_z   = 0;
   int m_out = 0;

   alu_acc #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .I        (I),
      .D        (D),
      .load_ACC (load_ACC),
      .load_OUT (load_OUT),
      .ACC      (ACC),
      .Z        (Z),
      .C        (C),
      .OUT      (OUT)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: total=%0d bad=%0d (time limit expired)", total, bad);
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   task automatic model_step(input int rst, input int la, input int lo,
                             input int op, input int d);
      int t;
      int old_acc;
      old_acc = m_acc;
      if (rst != 0) begin
         m_acc = 0; m_c = 0; m_z = 0; m_out = 0;
      end else begin
         if (la != 0 && op >= 1 && op <= 12) begin
            case (op)
               1:  m_acc = m_acc ^ d;
               2:  m_acc = m_acc & d;
               3:  m_acc = m_acc | d;
               4:  begin t = m_acc + d;               m_acc = t % 256; m_c = t / 256; end
               5:  begin t = m_acc + d + m_c;         m_acc = t % 256; m_c = t / 256; end
               6:  begin t = m_acc + (255 - d) + 1;   m_acc = t % 256; m_c = t / 256; end
               7:  begin t = m_acc + (255 - d) + m_c; m_acc = t % 256; m_c = t / 256; end
               8:  begin t = m_acc * 2 + m_c;         m_acc = t % 256; m_c = t / 256; end
               9:  begin t = m_c * 256 + m_acc;       m_c = t % 2;     m_acc = t / 2; end
               10: m_acc = d;
               11: begin m_c = m_acc / 128; m_acc = (m_acc * 2) % 256; end
               12: begin m_c = m_acc % 2;   m_acc = m_acc / 2; end
               default: ;
            endcase
            m_z = (m_acc == 0) ? 1 : 0;
         end
         if (lo != 0 && op == 13) m_out = old_acc;
      end
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of inputs, lets the edge happen, updates the model,
   // and returns on the following falling edge.
   task automatic do_cycle(input logic rst, input logic la, input logic lo,
                           input logic [7:0] op, input logic [7:0] d);
      reset    = rst;
      load_ACC = la;
      load_OUT = lo;
      I        = op;
      D        = d;
      @(posedge clk);
      model_step(int'(rst), int'(la), int'(lo), int'(op), int'(d));
      exp_q.push_back({m_out[7:0], m_z[0], m_c[0], m_acc[7:0]});
      @(negedge clk);
      #1;
   endtask

   // EXE cycle as the controller issues it: load_ACC and load_OUT together
   task automatic exe(input logic [7:0] op, input logic [7:0] d);
      do_cycle(1'b0, 1'b1, 1'b1, op, d);
   endtask

   task automatic check_lit(input string name, input logic [7:0] got,
                            input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%02h expected=0x%02h", name, got, exp);
      end
   endtask

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic [2*WIDTH+1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if ({OUT, Z, C, ACC} !== e) begin
            bad++;
            $display("FAIL state: got OUT=%02h Z=%0b C=%0b ACC=%02h expected OUT=%02h Z=%0b C=%0b ACC=%02h",
                     OUT, Z, C, ACC, e[17:10], e[9], e[8], e[7:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0; load_ACC = 1'b0; load_OUT = 1'b0; I = 8'd0; D = 8'd0;

      // Reset overrides a simultaneous LDA
      do_cycle(1'b1, 1'b1, 1'b0, 8'd10, 8'h55);
      check_lit("rst_acc", ACC, 8'h00);
      check_lit("rst_c",   {7'd0, C}, 8'h00);
      check_lit("rst_z",   {7'd0, Z}, 8'h00);
      check_lit("rst_out", OUT, 8'h00);

      // Carry chain
      exe(8'd10, 8'hF0);
      exe(8'd4,  8'h20);
      check_lit("add_acc", ACC, 8'h10);
      check_lit("add_c",   {7'd0, C}, 8'h01);
      check_lit("add_z",   {7'd0, Z}, 8'h00);
      exe(8'd5,  8'h00);
      check_lit("adc_acc", ACC, 8'h11);
      check_lit("adc_c",   {7'd0, C}, 8'h00);

      // Zero flag and borrow
      exe(8'd10, 8'h05);
      exe(8'd6,  8'h05);
      check_lit("sub_acc", ACC, 8'h00);
      check_lit("sub_c",   {7'd0, C}, 8'h01);
      check_lit("sub_z",   {7'd0, Z}, 8'h01);
      exe(8'd6,  8'h01);
      check_lit("sub2_acc", ACC, 8'hFF);
      check_lit("sub2_c",   {7'd0, C}, 8'h00);
      check_lit("sub2_z",   {7'd0, Z}, 8'h00);
      exe(8'd7,  8'h00);
      check_lit("sbc_acc", ACC, 8'hFE);
      check_lit("sbc_c",   {7'd0, C}, 8'h01);

      // Rotates and shifts (C is 1 here)
      exe(8'd10, 8'h80);
      exe(8'd8,  8'h00);
      check_lit("rol_acc", ACC, 8'h01);
      check_lit("rol_c",   {7'd0, C}, 8'h01);
      exe(8'd9,  8'h00);
      check_lit("ror_acc", ACC, 8'h80);
      check_lit("ror_c",   {7'd0, C}, 8'h01);
      exe(8'd12, 8'h00);
      check_lit("lsr_acc", ACC, 8'h40);
      check_lit("lsr_c",   {7'd0, C}, 8'h00);
      exe(8'd10, 8'h81);
      exe(8'd11, 8'h00);
      check_lit("lsl_acc", ACC, 8'h02);
      check_lit("lsl_c",   {7'd0, C}, 8'h01);

      // Logic ops leave C alone
      exe(8'd10, 8'h0F);
      exe(8'd2,  8'hF0);
      check_lit("and_acc", ACC, 8'h00);
      check_lit("and_z",   {7'd0, Z}, 8'h01);
      check_lit("and_c",   {7'd0, C}, 8'h01);
      exe(8'd10, 8'h3C);
      exe(8'd1,  8'hFF);
      check_lit("xor_acc", ACC, 8'hC3);
      exe(8'd3,  8'h0C);
      check_lit("or_acc",  ACC, 8'hCF);
      check_lit("or_c",    {7'd0, C}, 8'h01);

      // OUT qualification
      exe(8'd10, 8'h3C);
      do_cycle(1'b0, 1'b0, 1'b1, 8'd4, 8'h11);
      check_lit("out_hold", OUT, 8'h00);
      check_lit("out_hold_acc", ACC, 8'h3C);
      do_cycle(1'b0, 1'b1, 1'b1, 8'd13, 8'h77);
      check_lit("out_load", OUT, 8'h3C);
      check_lit("out_acc_keep", ACC, 8'h3C);
      do_cycle(1'b0, 1'b1, 1'b0, 8'd14, 8'h99);
      check_lit("op14_acc", ACC, 8'h3C);
      check_lit("op14_c",   {7'd0, C}, 8'h01);
      check_lit("op14_z",   {7'd0, Z}, 8'h00);

      // Undefined opcode must also hold a set Z; no strobe must hold ACC
      exe(8'd10, 8'h00);
      do_cycle(1'b0, 1'b1, 1'b1, 8'd0, 8'h42);
      check_lit("op0_z", {7'd0, Z}, 8'h01);
      do_cycle(1'b0, 1'b0, 1'b0, 8'd10, 8'h77);
      check_lit("nostrobe_acc", ACC, 8'h00);

      // Back-to-back chain, checked by the model only
      exe(8'd10, 8'hA5);
      exe(8'd5,  8'h5B);
      exe(8'd7,  8'h01);
      exe(8'd9,  8'h00);
      exe(8'd8,  8'h00);
      exe(8'd13, 8'h00);
      exe(8'd4,  8'hFF);
      exe(8'd13, 8'h00);

      // Mid-instruction reset with both strobes and I = OUT
      exe(8'd10, 8'h9E);
      exe(8'd13, 8'h00);
      do_cycle(1'b1, 1'b1, 1'b1, 8'd13, 8'h00);
      check_lit("rst2_acc", ACC, 8'h00);
      check_lit("rst2_out", OUT, 8'h00);

      do_cycle(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_acc.md
# alu_acc

Arithmetic/logic unit with accumulator, carry and zero flag registers, plus the output port register, for the 8-bit nanoprocessor. It sits directly downstream of the sequencing controller and consumes its `load_ACC` and `load_OUT` strobes together with the latched instruction opcode. It produces the `Z` and `C` flags that the controller consumes for conditional branches. During the EXE phase its second operand is the memory data word.

## Interface
Parameters:
- `WIDTH`, default 8: data path width (accumulator, operand, output port).

Ports:
- `clk` (in, 1): single clock; all state updates on its rising edge.
- `reset` (in, 1): synchronous, active-high; sampled on the rising edge of `clk`.
- `I` (in, 8): opcode from the instruction register; stable during EXE.
- `D` (in, WIDTH): operand from data memory, valid during EXE.
- `load_ACC` (in, 1): controller strobe; commit the ALU result and flags this edge.
- `load_OUT` (in, 1): controller strobe; update the output port if `I` is OUT.
- `ACC` (out, WIDTH): accumulator register; also the data written to memory.
- `Z` (out, 1): zero flag register.
- `C` (out, 1): carry flag register.
- `OUT` (out, WIDTH): output port register.

## Operation
- Registers: `ACC`, `C`, `Z` and `OUT`. The ALU itself is combinational from `I`, `ACC`, `D` and `C`.
- When `load_ACC` is 1, opcode `I` is applied. Each entry lists the new ACC, then the new C:
  - 1 XOR: ACC^D; C unchanged.
  - 2 AND: ACC&D; C unchanged.
  - 3 OR: ACC|D; C unchanged.
  - 4 ADD: ACC+D; C = carry out of bit WIDTH-1.
  - 5 ADC: ACC+D+C; C = carry out of bit WIDTH-1.
  - 6 SUB: ACC+~D+1; C = carry out, where 1 means no borrow.
  - 7 SBC: ACC+~D+C; C = carry out.
  - 8 ROL: {C,ACC} <= {ACC,C}, i.e. rotate left through carry.
  - 9 ROR: {ACC,C} <= {C,ACC}, i.e. rotate right through carry.
  - 10 LDA: ACC <= D; C unchanged.
  - 11 LSL: C <= ACC[WIDTH-1]; ACC <= ACC<<1.
  - 12 LSR: C <= ACC[0]; ACC <= ACC>>1.
  - Any other opcode with `load_ACC` = 1: ACC, C and Z hold. This is a defensive case; the controller never produces it.
- Z rule: `Z` is set to (new ACC == 0) on every edge where `load_ACC` = 1 and 1 ≤ I ≤ 12. Otherwise it holds.
- Arithmetic: all sums are computed at WIDTH+1 bits. Bit WIDTH is the carry and is discarded from ACC, so results wrap modulo 2^WIDTH.
- OUT: when `load_OUT` = 1 and I == 13, OUT <= ACC, where ACC is the value before any same-edge update. In all other cases OUT holds. The controller raises `load_OUT` in every EXE cycle, so the opcode qualification is mandatory.
- Simultaneous `load_ACC` and `load_OUT` with I == 13 cannot update ACC, because 13 is outside 1..12. OUT takes the current ACC.
- The block holds no internal FSM. Sequencing is owned by the controller (IF → AF → EXE); this block acts only on the EXE strobes.

## Timing
- Reset: ACC = 0, C = 0, Z = 0, OUT = 0, from the first rising edge with `reset` = 1. Reset overrides `load_ACC` and `load_OUT` on the same edge.
- Reset asserted mid-instruction: the EXE result is discarded and all registers go to 0.
- Latency: the result, C and Z are visible the cycle after the EXE edge. This is the following IF cycle, so a branch in the next instruction sees the updated flags.
- `ACC` feeds memory write data combinationally from the register; it is stable through the whole EXE cycle.
- No handshake. The strobes are single-cycle pulses, and back-to-back pulses are processed on every edge, using the prior result as the ACC input.

## Test plan
- Reset: drive `reset` = 1 for 1 edge with `load_ACC` = 1, I = 10, D = 0x55 → ACC = 0, C = 0, Z = 0, OUT = 0.
- Load and add with carry chain: LDA 0xF0 then ADD 0x20 → ACC = 0x10, C = 1, Z = 0. Follow with ADC 0x00 → ACC = 0x11, C = 0.
- Zero flag and borrow: LDA 0x05 then SUB 0x05 → ACC = 0x00, C = 1, Z = 1. Then SUB 0x01 → ACC = 0xFF, C = 0, Z = 0. Then SBC 0x00 → ACC = 0xFE, C = 1.
- Rotates and shifts: C = 1, ACC = 0x80, ROL → ACC = 0x01, C = 1. Then ROR → ACC = 0x80, C = 1. Then LSR → ACC = 0x40, C = 0. Then LSL with ACC = 0x81 → ACC = 0x02, C = 1.
- Logic ops keep C: C = 1, ACC = 0x0F, AND 0xF0 → ACC = 0x00, Z = 1, C = 1.
- OUT qualification: ACC = 0x3C. Pulse `load_OUT` with I = 4 → OUT unchanged (0). Pulse with I = 13 → OUT = 0x3C. Opcode 14 with `load_ACC` = 1 → ACC, C and Z hold.
